// File: rtl/fir_ci_arbiter.sv
// Two-requester, credit-limited arbiter in front of one pipelined FIR custom-instruction unit.
// Define FIR_ARB_FIXED_PRIO_EN to give requester 0 fixed priority (the round-robin pointer is then removed).
module fir_ci_arbiter #(
    parameter int LATENCY = 4,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] dataa_0,
    input  logic [31:0] dataa_1,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic [31:0] unit_dataa,
    output logic        unit_clk_en,
    output logic        unit_aclr,
    input  logic [31:0] unit_result
);

    localparam logic [2:0] CREDITS = 3'(MAX_OUT);

    logic [2:0]       cnt0_q, cnt0_d;
    logic [2:0]       cnt1_q, cnt1_d;
    logic [1:0]       elig;
    logic [1:0]       acc;
    logic [LATENCY:0] vld_q;
    logic [LATENCY:0] id_q;
    logic [31:0]      dataa_q;
    logic             aclr_q;

    function automatic logic [2:0] credit_next(input logic [2:0] cnt,
                                                input logic       take,
                                                input logic       give);
        logic [2:0] n;
        n = cnt;
        if (take && !give && cnt != 3'd7) begin
            n = cnt + 3'd1;
        end else if (give && !take && cnt != 3'd0) begin
            n = cnt - 3'd1;
        end
        return n;
    endfunction

    assign elig[0] = req[0] & (cnt0_q < CREDITS);
    assign elig[1] = req[1] & (cnt1_q < CREDITS);
    assign acc     = req & gnt;

`ifdef FIR_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = 2'b00;
        if (reset) begin
            if (elig[0]) begin
                gnt = 2'b01;
            end else if (elig[1]) begin
                gnt = 2'b10;
            end
        end
    end
`else
    logic prio_q, prio_d;

    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        if (reset) begin
            if (elig == 2'b11) begin
                gnt = prio_q ? 2'b10 : 2'b01;
            end else if (elig[0]) begin
                gnt = 2'b01;
            end else if (elig[1]) begin
                gnt = 2'b10;
            end
        end
        // pointer always moves away from whoever was just accepted
        if (acc[0]) begin
            prio_d = 1'b1;
        end else if (acc[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign cnt0_d = credit_next(cnt0_q, acc[0], rsp_valid[0]);
    assign cnt1_d = credit_next(cnt1_q, acc[1], rsp_valid[1]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt0_q <= 3'd0;
            cnt1_q <= 3'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    // issue stage: operand register feeding the unit
    always_ff @(posedge clk) begin
        if (!reset) begin
            dataa_q <= 32'd0;
        end else if (acc[0]) begin
            dataa_q <= dataa_0;
        end else if (acc[1]) begin
            dataa_q <= dataa_1;
        end
    end

    // tag pipe, LATENCY+1 deep so the last stage lines up with unit_result
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LATENCY-1:0], |acc};
        end
        id_q <= {id_q[LATENCY-1:0], acc[1]};
    end

    always_ff @(posedge clk) begin
        aclr_q <= ~reset;
    end

    assign rsp_valid   = {vld_q[LATENCY] & id_q[LATENCY], vld_q[LATENCY] & ~id_q[LATENCY]};
    assign rsp_data    = unit_result;
    assign busy        = (cnt0_q != 3'd0) | (cnt1_q != 3'd0);
    assign unit_dataa  = dataa_q;
    assign unit_clk_en = reset;
    assign unit_aclr   = aclr_q;

endmodule

// File: doc/fir_ci_arbiter.md
# fir_ci_arbiter

Shares one pipelined FIR custom-instruction datapath between two requesters, typically the Nios II custom-instruction port and the accelerometer sampling path. It arbitrates operand issue round-robin, at most one operand per cycle. Each requester has a credit limit on outstanding operations. Issued operations are tagged through a latency-matched pipe so each result returns only to the requester that issued it.

## Interface
Parameters:
- LATENCY, 4: cycles from operand at `unit_dataa` to valid `unit_result`; legal range 1–16.
- MAX_OUT, 2: maximum outstanding operations per requester; legal range 1–7.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  2  per-requester issue request; `req[i]` must hold with `dataa_i` stable until granted.
- dataa_0  in  32  operand from requester 0.
- dataa_1  in  32  operand from requester 1.
- gnt  out  2  one-hot-or-zero grant. Combinational within the cycle. Accept occurs when `req[i] & gnt[i]` is high at a rising edge.
- rsp_valid  out  2  one-hot-or-zero result strobe, one cycle per operation.
- rsp_data  out  32  result; meaningful only while any `rsp_valid` bit is high.
- busy  out  1  high while any operation is in flight.
- unit_dataa  out  32  registered operand to the FIR unit.
- unit_clk_en  out  1  FIR unit clock enable.
- unit_aclr  out  1  FIR unit clear.
- unit_result  in  32  FIR unit output.

## Operation
- Round-robin pointer `prio` names the favoured requester.
- Grant eligibility: requester i is eligible when `req[i]` is high and `cnt_i < MAX_OUT`.
- Grant selection:
  - Both eligible: grant `prio`.
  - One eligible: grant it.
  - While reset is low: `gnt = 0`.
- Pointer update: after an accept by requester i, `prio` moves to the other requester. With no accept, `prio` holds.
- On accept:
  - `unit_dataa <= dataa_i`.
  - Tag `{valid=1, id=i}` enters stage 0 of a (LATENCY+1)-deep tag shift register.
  - With no accept, a `{valid=0}` tag enters instead.
- Tag pipe advances every cycle and never stalls.
- Result routing: `rsp_valid[id] = valid` of the final stage, and `rsp_data = unit_result` (combinational).
- Credit counters `cnt_0`, `cnt_1` are 3 bits wide:
  - Increment on accept.
  - Decrement on `rsp_valid[i]`.
  - Accept and response to the same requester in one cycle: count unchanged.
  - The counter can never exceed MAX_OUT or underflow.
- `busy = (cnt_0 != 0) | (cnt_1 != 0)`.
- `unit_clk_en` is 1 whenever reset is high, so the unit runs continuously.
- `unit_aclr` is a registered copy of `~reset`: it asserts one cycle after reset falls and deasserts one cycle after reset rises.

## Timing
- Accept in cycle c → `unit_dataa` valid in c+1 → `rsp_valid[i]` and `rsp_data` in cycle c+1+LATENCY. Default LATENCY: 5 cycles after the accept.
- Throughput: one accept per cycle, alternating between requesters when both are eligible.
- Credit release: a credit freed by `rsp_valid` in cycle r is usable for a grant in cycle r+1, not in r.
- Results return in issue order. Responses for different requesters never coincide, because at most one accept occurs per cycle.
- Reset values (applied at the first edge with reset low):
  - All tags invalid; `rsp_valid = 0`.
  - `cnt_0 = cnt_1 = 0`; `busy = 0`.
  - `prio = 0`; `unit_dataa = 0`.
  - `unit_aclr = 1` from the following cycle.
- Reset mid-operation: all in-flight tags are discarded, and no `rsp_valid` fires for operations accepted before reset. The first grant is possible in the first cycle with reset high.
- A requester dropping `req` before grant is legal and leaves no state.

## Configuration
- FIR_ARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins when both are eligible; the `prio` register is removed.
  - Undefined (default): round-robin as above.
- Credit limits and latency behaviour are identical in both builds.

## Test plan
- Single issue, LATENCY=4: `req=01` with `dataa_0=0x0000_0010` accepted in cycle 10 → `rsp_valid=01` in cycle 15 only, with `rsp_data` equal to `unit_result` in that cycle; `busy` high in cycles 11–15.
- Contention: `req=11` held for 6 cycles → grants 01,10,01,10,… (round-robin build). With FIR_ARB_FIXED_PRIO_EN defined, `gnt=01` until `cnt_0=MAX_OUT`; then requester 1 is granted.
- Credit limit, MAX_OUT=2: requester 0 requests continuously → accepts in cycles c and c+1. `gnt[0]=0` until `rsp_valid[0]` in c+5, and the next accept occurs in c+6.
- Simultaneous accept and response for requester 0 with `cnt_0=1` → `cnt_0` stays 1 and the grant sequence continues unbroken.
- Reset mid-flight: three operations outstanding, reset low for 1 cycle → no `rsp_valid` afterwards, `busy=0`, `prio=0`, and `unit_aclr` pulses for 1 cycle. A fresh request is accepted in the first cycle after reset rises.
